// File: rtl/fifo_gearbox_20to16.sv
// 20-bit to 16-bit FWFT gearbox: pops 20-bit FIFO words and repacks them LSB-first
// into a 16-bit FWFT stream; a flush zero-pads a trailing partial word.
module fifo_gearbox_20to16 (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic [19:0] IN_DO,
  input  logic        IN_EMPTY,
  output logic        IN_RDEN,
  input  logic        FLUSH,
  output logic [15:0] DO,
  output logic        DO_PAD,
  output logic        EMPTY,
  input  logic        RDEN,
  output logic        RDERR
);

  logic [35:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        flush_pend_q, flush_pend_d;
  logic        pad_flag_q, pad_flag_d;
  logic [15:0] do_q, do_d;
  logic        do_pad_q, do_pad_d;
  logic        empty_q, empty_d;
  logic        rderr_q, rderr_d;

  logic        out_ready;
  logic        take;
  logic [5:0]  cnt_after;
  logic [35:0] acc_after;
  logic [35:0] in_ext;
  logic        flush_exec;

  assign out_ready = empty_q | RDEN;
  assign take      = out_ready & (cnt_q >= 6'd16);
  assign cnt_after = take ? (cnt_q - 6'd16) : cnt_q;
  assign acc_after = take ? {16'd0, acc_q[35:16]} : acc_q;
  assign in_ext    = {16'd0, IN_DO} << cnt_after;

  // Room for one more 20-bit word: at most 16 bits left once any take is applied.
  assign IN_RDEN = reset_n & ~IN_EMPTY &
                   ((cnt_q <= 6'd16) | (take & (cnt_q <= 6'd32)));

  assign flush_exec = flush_pend_q & (cnt_q != 6'd0) & (cnt_q < 6'd16) & ~IN_RDEN;

  always_comb begin
    acc_d        = acc_after;
    cnt_d        = cnt_after;
    flush_pend_d = flush_pend_q;
    pad_flag_d   = pad_flag_q;
    do_d         = do_q;
    do_pad_d     = do_pad_q;
    empty_d      = empty_q;
    rderr_d      = RDEN & empty_q;

    if (take) begin
      do_d       = acc_q[15:0];
      do_pad_d   = pad_flag_q;
      empty_d    = 1'b0;
      pad_flag_d = 1'b0;
    end else if (out_ready) begin
      empty_d = 1'b1;
    end

    if (IN_RDEN) begin
      acc_d = acc_after | in_ext;
      cnt_d = cnt_after + 6'd20;
    end

    // Zero fill above cnt is already guaranteed, so padding only moves cnt.
    if (flush_exec) begin
      cnt_d        = 6'd16;
      pad_flag_d   = 1'b1;
      flush_pend_d = 1'b0;
    end else if (flush_pend_q & ~IN_RDEN & (cnt_q == 6'd0)) begin
      flush_pend_d = 1'b0;
    end

    if (FLUSH) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      pad_flag_q   <= 1'b0;
      do_q         <= '0;
      do_pad_q     <= 1'b0;
      empty_q      <= 1'b1;
      rderr_q      <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      pad_flag_q   <= pad_flag_d;
      do_q         <= do_d;
      do_pad_q     <= do_pad_d;
      empty_q      <= empty_d;
      rderr_q      <= rderr_d;
    end
  end

  assign DO     = do_q;
  assign DO_PAD = do_pad_q;
  assign EMPTY  = empty_q;
  assign RDERR  = rderr_q;

endmodule

// File: tb/tb_fifo_gearbox_20to16.sv
// Directed + randomized bench for fifo_gearbox_20to16, scored against a bit-queue
// model of the LSB-first stream (pad length recovered from stream arithmetic).
module tb_fifo_gearbox_20to16;

  logic        clk;
  logic        reset_n;
  logic [19:0] in_do;
  logic        in_empty;
  logic        in_rden;
  logic        flush;
  logic [15:0] dout;
  logic        do_pad;
  logic        empty;
  logic        rden;
  logic        rderr;

  fifo_gearbox_20to16 dut (
    .CLK      (clk),
    .reset_n  (reset_n),
    .IN_DO    (in_do),
    .IN_EMPTY (in_empty),
    .IN_RDEN  (in_rden),
    .FLUSH    (flush),
    .DO       (dout),
    .DO_PAD   (do_pad),
    .EMPTY    (empty),
    .RDEN     (rden),
    .RDERR    (rderr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          ncmp = 0;
  int          nerr = 0;
  bit          mq[$];
  logic [19:0] src_q[$];
  logic [15:0] got_do[$];
  bit          got_pad[$];
  int          pops = 0;
  int          consumed = 0;
  logic        last_empty, last_in_rden, last_rderr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic consume();
    int          pend;
    int          r;
    logic [15:0] exp;
    pend = mq.size();
    exp  = '0;
    if (do_pad) begin
      // Bits entered after the flush arrive in whole 20-bit words, so the
      // residue modulo 20 is the real content of the padded word.
      r = pend % 20;
      chk("pad_len_range", 64'(r >= 1 && r <= 15), 64'd1);
    end else begin
      r = 16;
      chk("bits_available", 64'(pend >= 16), 64'd1);
    end
    for (int i = 0; i < 16; i++) if (i < r && i < mq.size()) exp[i] = mq[i];
    chk(do_pad ? "pad_word" : "data_word", 64'(dout), 64'(exp));
    for (int i = 0; i < r; i++) if (mq.size() > 0) void'(mq.pop_front());
    got_do.push_back(dout);
    got_pad.push_back(do_pad);
    consumed++;
  endtask

  task automatic step(input bit hold_in, input bit rd, input bit fl);
    logic [19:0] w;
    in_empty = hold_in || (src_q.size() == 0);
    in_do    = (src_q.size() != 0) ? src_q[0] : 20'h0;
    rden     = rd;
    flush    = fl;
    #1;
    last_empty   = empty;
    last_in_rden = in_rden;
    last_rderr   = rderr;
    if (in_empty) chk("in_rden_when_in_empty", 64'(in_rden), 64'd0);
    if (rd && !empty) consume();
    if (in_rden && !in_empty) begin
      w = src_q.pop_front();
      for (int i = 0; i < 20; i++) mq.push_back(w[i]);
      pops++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    src_q.delete();
    reset_n  = 1'b0;
    in_empty = 1'b0;
    in_do    = 20'h5A5A5;
    rden     = 1'b0;
    flush    = 1'b0;
    #1;
    chk("rst_in_rden", 64'(in_rden), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_do", 64'(dout), 64'd0);
    chk("rst_do_pad", 64'(do_pad), 64'd0);
    chk("rst_rderr", 64'(rderr), 64'd0);
    mq.delete();
    in_empty = 1'b1;
    reset_n  = 1'b1;
  endtask

  initial begin
    int base, n, first, c0, p0;
    reset_n  = 1'b0;
    in_empty = 1'b1;
    in_do    = '0;
    rden     = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    do_reset();

    // Pack order and first-output latency
    base = consumed;
    src_q.push_back(20'hABCDE); src_q.push_back(20'h12345);
    src_q.push_back(20'h6789A); src_q.push_back(20'hBCDEF);
    step(0, 1, 0);
    chk("lat_pop_now", 64'(last_in_rden), 64'd1);
    step(0, 1, 0);
    chk("lat_empty_k1", 64'(last_empty), 64'd1);
    step(0, 1, 0);
    chk("lat_valid_k2", 64'(last_empty), 64'd0);
    n = 0;
    while (consumed - base < 5 && n < 20) begin step(0, 1, 0); n++; end
    chk("pack_count", 64'(consumed - base), 64'd5);
    if (consumed - base == 5) begin
      chk("pack_w0", 64'(got_do[base+0]), 64'h BCDE);
      chk("pack_w1", 64'(got_do[base+1]), 64'h345A);
      chk("pack_w2", 64'(got_do[base+2]), 64'h9A12);
      chk("pack_w3", 64'(got_do[base+3]), 64'hF678);
      chk("pack_w4", 64'(got_do[base+4]), 64'hBCDE);
      for (int i = 0; i < 5; i++) chk("pack_nopad", 64'(got_pad[base+i]), 64'd0);
    end
    step(1, 1, 0);
    chk("pack_empty_after", 64'(empty), 64'd1);
    chk("pack_no_residue", 64'(mq.size()), 64'd0);

    // Flush of a trailing partial word
    base = consumed;
    src_q.push_back(20'hABCDE);
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    step(1, 1, 1);
    n = 0;
    while (consumed - base < 2 && n < 10) begin step(1, 1, 0); n++; end
    chk("flush_count", 64'(consumed - base), 64'd2);
    if (consumed - base == 2) begin
      chk("flush_w0", 64'(got_do[base]), 64'hBCDE);
      chk("flush_w0_pad", 64'(got_pad[base]), 64'd0);
      chk("flush_w1", 64'(got_do[base+1]), 64'h000A);
      chk("flush_w1_pad", 64'(got_pad[base+1]), 64'd1);
    end
    step(1, 1, 0);
    chk("flush_empty_after", 64'(empty), 64'd1);

    // Flush with nothing buffered
    base = consumed;
    step(1, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 0);
    chk("flush_cnt0_no_out", 64'(consumed - base), 64'd0);
    chk("flush_cnt0_empty", 64'(empty), 64'd1);

    // Read error flag
    step(1, 1, 0);
    step(1, 0, 0);
    chk("rderr_set", 64'(last_rderr), 64'd1);
    step(1, 0, 0);
    chk("rderr_clear", 64'(last_rderr), 64'd0);

    // Backpressure then release
    p0 = pops;
    for (int i = 0; i < 8; i++) src_q.push_back(20'($urandom));
    for (int i = 0; i < 12; i++) step(0, 0, 0);
    chk("bp_pops", 64'(pops - p0), 64'd2);
    chk("bp_do_held", 64'(empty), 64'd0);
    c0 = consumed;
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    chk("bp_release_words", 64'(consumed - c0), 64'd10);
    chk("bp_empty_after", 64'(empty), 64'd1);

    // Throughput
    for (int i = 0; i < 400; i++) src_q.push_back(20'($urandom));
    c0 = consumed; n = 0; first = -1;
    while (consumed - c0 < 500 && n < 1000) begin
      base = consumed;
      step(0, 1, 0);
      if (first < 0 && consumed > base) first = n;
      n++;
    end
    chk("tput_words", 64'(consumed - c0), 64'd500);
    chk("tput_window", 64'((n - first) >= 498 && (n - first) <= 502), 64'd1);
    step(1, 1, 0);

    // Reset mid-stream with 12 residual bits
    for (int i = 0; i < 3; i++) src_q.push_back(20'($urandom));
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    chk("pre_rst_residual", 64'(mq.size()), 64'd12);
    do_reset();
    base = consumed;
    step(1, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 0);
    chk("rst_dropped_residual", 64'(consumed - base), 64'd0);
    chk("rst_empty_after", 64'(empty), 64'd1);

    // Random mix
    for (int i = 0; i < 10000; i++) begin
      while (src_q.size() < 2) src_q.push_back(20'($urandom));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
      if (mq.size() > 52) chk("occupancy_bound", 64'(mq.size()), 64'd52);
    end
    chk("occupancy_final_bound", 64'(mq.size() <= 52), 64'd1);
    src_q.delete();
    step(1, 0, 1);
    n = 0;
    while (mq.size() != 0 && n < 40) begin step(1, 1, 0); n++; end
    chk("drain_residual", 64'(mq.size()), 64'd0);
    step(1, 1, 0);
    chk("drain_empty", 64'(empty), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_gearbox_20to16.md
# fifo_gearbox_20to16

Downstream consumer of the 20-bit BRAM FWFT FIFO. It pops 20-bit words from the FIFO's read port and repacks them LSB-first into a continuous 16-bit stream: four input words produce five output words. The output is itself an FWFT port, so it feeds the 16-bit high-speed interface directly. A flush request pads a trailing partial word with zeros so that no captured bits are stranded.

## Interface
- No parameters. Widths are fixed at 20 bits in and 16 bits out.
- CLK  in  1  Sole clock. Must be the FIFO's RDCLK domain.
- reset_n  in  1  Synchronous, active-low reset, sampled on rising CLK.
- IN_DO  in  20  FIFO read data, valid while IN_EMPTY=0.
- IN_EMPTY  in  1  FIFO empty flag.
- IN_RDEN  out  1  FIFO read enable. Combinational; pops IN_DO at this edge.
- FLUSH  in  1  Single-cycle request to pad and emit any residual bits.
- DO  out  16  Output word, valid while EMPTY=0.
- DO_PAD  out  1  Current DO contains zero padding inserted by a flush.
- EMPTY  out  1  Output empty flag, FWFT semantics.
- RDEN  in  1  Downstream read enable. Consumes DO at this edge.
- RDERR  out  1  Registered flag: RDEN was asserted while EMPTY=1 on the previous edge.

## Operation
- **State**
  - acc[35:0]: bit accumulator, LSB is the oldest bit.
  - cnt[5:0]: valid bits in acc, range 0..36.
  - flush_pend: pending flush.
  - pad_flag: marks padded bits.
  - Output registers DO, DO_PAD, EMPTY, RDERR.
- **Invariant:** acc bits at positions ≥ cnt are always 0.
- **take** = (EMPTY | RDEN) & (cnt ≥ 16).
  - On take: DO ← acc[15:0], DO_PAD ← pad_flag, EMPTY ← 0, acc ← acc >> 16, cnt ← cnt − 16.
- **Output with nothing to give:** if (EMPTY | RDEN) and cnt < 16, then EMPTY ← 1 and DO holds its last value.
- **IN_RDEN** = reset_n & ~IN_EMPTY & (cnt ≤ 16 | (take & cnt ≤ 32)).
  - On accept: acc ← (acc after take) | (IN_DO << cnt_after), cnt ← cnt_after + 20.
  - cnt_after is cnt, minus 16 if take occurs in the same cycle.
- **Flush**
  - FLUSH=1 sets flush_pend.
  - A flush is executed when flush_pend=1, 1 ≤ cnt ≤ 15, and IN_RDEN=0 in that cycle: cnt ← 16 (zero fill is implicit), pad_flag ← 1, flush_pend ← 0.
  - If cnt = 0, flush_pend clears with no output.
  - If cnt ≥ 16, or an input is accepted, flush_pend stays set until the flush condition holds.
  - pad_flag clears when the padded word is taken.
- **Error:** RDERR ← RDEN & EMPTY every cycle. This is status only; a read while EMPTY=1 changes no state.
- **Reset (reset_n=0 at edge):**
  - acc=0, cnt=0, flush_pend=0, pad_flag=0.
  - DO=0, DO_PAD=0, EMPTY=1, RDERR=0.
  - IN_RDEN is forced to 0 while reset_n=0.
  - Reset mid-stream discards all residual bits; no partial word is emitted.

## Timing
- **Latency:** with cnt=0, IN_EMPTY falls in cycle k, so IN_RDEN=1 in cycle k and the word is popped at edge k. The first output DO is valid (EMPTY=0) after edge k+1.
- **Throughput:** with a continuously non-empty input and RDEN held high, the block outputs 1 word per cycle and pops 4 input words per 5 cycles. cnt cycles through 20→24→28→32→36→20.
- **Backpressure:** if RDEN stays low with EMPTY=0, cnt rises to at most 36, after which IN_RDEN=0. No bits are lost and no overflow occurs.
- **Combinational paths:**
  - RDEN → IN_RDEN (via take).
  - IN_EMPTY → IN_RDEN.
  - All outputs other than IN_RDEN are registered.
- **FLUSH timing:** a flush asserted while input is streaming executes only when the input pauses with 1 ≤ cnt ≤ 15. The padded word appears on DO one edge after the flush executes.

## Test plan
- **Pack order:** push 0xABCDE, 0x12345, 0x6789A, 0xBCDEF, with RDEN=1 → DO sequence 0xBCDE, 0x345A, 0x9A12, 0xF678, 0xBCDE, all with DO_PAD=0, then EMPTY=1 with cnt=0.
- **Flush:** push only 0xABCDE, then pulse FLUSH → 0xBCDE (DO_PAD=0), then 0x000A (DO_PAD=1), then EMPTY=1. A FLUSH with cnt=0 → no output.
- **Backpressure:** hold RDEN=0 with 8 words queued → exactly 2 input pops (cnt=40 is never reached; the first output stays in DO). Releasing RDEN → 10 correct output words in order, with no gaps once streaming.
- **Throughput:** 400 random words with IN_EMPTY=0 and RDEN=1 → 500 outputs in 500±2 cycles; the output matches the reference bit-stream model.
- **Errors and reset:** RDEN=1 while EMPTY=1 → RDERR=1 the next cycle. reset_n=0 with cnt=12 → all outputs reset as specified, residual bits dropped, IN_RDEN=0 during reset.
- **Random mix:** random IN_EMPTY, RDEN, and FLUSH over 10k cycles → scoreboard match on the bit stream (padding excluded), and cnt never exceeds 36.
